// File: rtl/cnnip_pkg.sv
// -----------------------------------------------------------------------------
// cnnip_pkg
// Shared definitions for the CNN IP: row/kernel counter widths, the
// convolution sequencer FSM state type and the padded-height helper.
// No ports (package).
// -----------------------------------------------------------------------------
package cnnip_pkg;

   localparam int unsigned ROW_W = 10;  // row coordinates in padded space
   localparam int unsigned KN_W  = 8;   // kernel size / kernel count / kernel index

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StCheck = 3'd1,
      StIssue = 3'd2,
      StWait  = 3'd3,
      StDone  = 3'd4
   } seq_state_e;

   // Padded height P = ifmap + 2*(K>>1) when padding is enabled.
   function automatic logic [ROW_W-1:0] padded_height(input logic [ROW_W-1:0] ifmap,
                                                      input logic [KN_W-1:0]  k,
                                                      input logic             pad_en);
      logic [ROW_W-1:0] pad;
      pad = pad_en ? ROW_W'(k >> 1) : '0;
      return ifmap + (pad << 1);
   endfunction

endpackage

// File: rtl/conv_loop_counter.sv
// -----------------------------------------------------------------------------
// conv_loop_counter
// Walks the (kernel, row) job space of one convolution command and flags the
// final job.
// Ports:
//   clk_a, arstz_aq     clock / async active-low reset
//   clear               restart at kernel 0, row 0
//   advance             step to the next job (current job finished)
//   cfg_k, cfg_n        latched kernel height K and kernel count N
//   cfg_s, cfg_p        latched stride S and padded height P
//   kernel, row_base,   current job coordinates
//   out_row
//   last                current job is the final one of the command
// -----------------------------------------------------------------------------
module conv_loop_counter
   import cnnip_pkg::*;
(
   input  logic             clk_a,
   input  logic             arstz_aq,
   input  logic             clear,
   input  logic             advance,
   input  logic [KN_W-1:0]  cfg_k,
   input  logic [KN_W-1:0]  cfg_n,
   input  logic [1:0]       cfg_s,
   input  logic [ROW_W-1:0] cfg_p,
   output logic [KN_W-1:0]  kernel,
   output logic [ROW_W-1:0] row_base,
   output logic [ROW_W-1:0] out_row,
   output logic             last
);

   logic [KN_W-1:0]  kernel_q;
   logic [ROW_W-1:0] row_base_q;
   logic [ROW_W-1:0] out_row_q;
   logic [ROW_W-1:0] next_end;
   logic             row_wrap;

   // Bottom edge (exclusive) of the window one stride further down; if it
   // falls outside the padded map this kernel has no more rows.
   assign next_end = row_base_q + ROW_W'(cfg_s) + ROW_W'(cfg_k);
   assign row_wrap = next_end > cfg_p;

   always_ff @(posedge clk_a or negedge arstz_aq) begin
      if (!arstz_aq) begin
         kernel_q   <= '0;
         row_base_q <= '0;
         out_row_q  <= '0;
      end else if (clear) begin
         kernel_q   <= '0;
         row_base_q <= '0;
         out_row_q  <= '0;
      end else if (advance) begin
         if (row_wrap) begin
            row_base_q <= '0;
            out_row_q  <= '0;
            kernel_q   <= kernel_q + KN_W'(1);
         end else begin
            row_base_q <= row_base_q + ROW_W'(cfg_s);
            out_row_q  <= out_row_q + ROW_W'(1);
         end
      end
   end

   assign kernel   = kernel_q;
   assign row_base = row_base_q;
   assign out_row  = out_row_q;
   assign last     = row_wrap && (kernel_q == (cfg_n - KN_W'(1)));

endmodule

// File: rtl/conv_sequencer.sv
// -----------------------------------------------------------------------------
// conv_sequencer
// Turns a software start command into a stream of row jobs for the PE array,
// one outstanding job at a time, then reports completion status.
// Ports:
//   clk_a, arstz_aq        clock / async active-low reset
//   CMD_START              start level (acts on its rising edge only)
//   MODE_KERNEL_SIZE/NUMS  kernel height K / kernel count N
//   MODE_STRIDE            row stride S
//   MODE_PADDING           pad K>>1 rows top and bottom
//   CMD_DONE               completion status (1 ok, 0 config error)
//   CMD_DONE_VALID         one-cycle strobe qualifying CMD_DONE
//   job_valid/job_ready    row job handshake
//   job_kernel, job_row_base, job_out_row, job_last   job fields
//   row_done               accepted job finished
//   busy                   command in progress
// -----------------------------------------------------------------------------
module conv_sequencer
   import cnnip_pkg::*;
#(
   parameter int unsigned IFMAP_SIZE = 32
) (
   input  logic             clk_a,
   input  logic             arstz_aq,
   input  logic             CMD_START,
   input  logic [7:0]       MODE_KERNEL_SIZE,
   input  logic [7:0]       MODE_KERNEL_NUMS,
   input  logic [1:0]       MODE_STRIDE,
   input  logic             MODE_PADDING,
   output logic             CMD_DONE,
   output logic             CMD_DONE_VALID,
   output logic             job_valid,
   input  logic             job_ready,
   output logic [KN_W-1:0]  job_kernel,
   output logic [ROW_W-1:0] job_row_base,
   output logic [ROW_W-1:0] job_out_row,
   output logic             job_last,
   input  logic             row_done,
   output logic             busy
);

   seq_state_e       state_q;
   logic             start_q;
   logic [KN_W-1:0]  cfg_k_q;
   logic [KN_W-1:0]  cfg_n_q;
   logic [1:0]       cfg_s_q;
   logic [ROW_W-1:0] cfg_p_q;
   logic             job_valid_q;
   logic             done_q;
   logic             done_valid_q;
   logic             busy_q;

   logic [ROW_W-1:0] chk_p;
   logic             cfg_err;
   logic             ctr_clear;
   logic             ctr_advance;
   logic             ctr_last;

   // Config is judged straight from the mode inputs in CHECK, the same cycle
   // it is latched.
   assign chk_p   = padded_height(ROW_W'(IFMAP_SIZE), MODE_KERNEL_SIZE, MODE_PADDING);
   assign cfg_err = (MODE_KERNEL_SIZE == '0) || (MODE_KERNEL_NUMS == '0) ||
                    (MODE_STRIDE == '0) || (ROW_W'(MODE_KERNEL_SIZE) > chk_p);

   assign ctr_clear   = (state_q == StCheck);
   assign ctr_advance = (state_q == StWait) && row_done;

   always_ff @(posedge clk_a or negedge arstz_aq) begin
      if (!arstz_aq) begin
         state_q      <= StIdle;
         start_q      <= 1'b0;
         cfg_k_q      <= '0;
         cfg_n_q      <= '0;
         cfg_s_q      <= '0;
         cfg_p_q      <= '0;
         job_valid_q  <= 1'b0;
         done_q       <= 1'b0;
         done_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         start_q      <= CMD_START;
         done_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (CMD_START && !start_q) begin
                  state_q <= StCheck;
                  busy_q  <= 1'b1;
               end
            end
            StCheck: begin
               cfg_k_q <= MODE_KERNEL_SIZE;
               cfg_n_q <= MODE_KERNEL_NUMS;
               cfg_s_q <= MODE_STRIDE;
               cfg_p_q <= chk_p;
               if (cfg_err) begin
                  state_q      <= StDone;
                  done_q       <= 1'b0;
                  done_valid_q <= 1'b1;
               end else begin
                  state_q     <= StIssue;
                  job_valid_q <= 1'b1;
               end
            end
            StIssue: begin
               if (job_ready) begin
                  state_q     <= StWait;
                  job_valid_q <= 1'b0;
               end
            end
            StWait: begin
               // Counters still describe the finished job here, so ctr_last
               // tells whether it was the final one.
               if (row_done) begin
                  if (ctr_last) begin
                     state_q      <= StDone;
                     done_q       <= 1'b1;
                     done_valid_q <= 1'b1;
                  end else begin
                     state_q     <= StIssue;
                     job_valid_q <= 1'b1;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   conv_loop_counter u_loop (
      .clk_a    (clk_a),
      .arstz_aq (arstz_aq),
      .clear    (ctr_clear),
      .advance  (ctr_advance),
      .cfg_k    (cfg_k_q),
      .cfg_n    (cfg_n_q),
      .cfg_s    (cfg_s_q),
      .cfg_p    (cfg_p_q),
      .kernel   (job_kernel),
      .row_base (job_row_base),
      .out_row  (job_out_row),
      .last     (ctr_last)
   );

   assign job_last       = ctr_last;
   assign job_valid      = job_valid_q;
   assign CMD_DONE       = done_q;
   assign CMD_DONE_VALID = done_valid_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_conv_sequencer
// Directed bench for conv_sequencer with IFMAP_SIZE = 32.
// -----------------------------------------------------------------------------
module tb_conv_sequencer;

   logic        clk_a = 1'b0;
   logic        arstz_aq = 1'b0;
   logic        CMD_START = 1'b0;
   logic [7:0]  MODE_KERNEL_SIZE = 8'd0;
   logic [7:0]  MODE_KERNEL_NUMS = 8'd0;
   logic [1:0]  MODE_STRIDE = 2'd0;
   logic        MODE_PADDING = 1'b0;
   logic        CMD_DONE;
   logic        CMD_DONE_VALID;
   logic        job_valid;
   logic        job_ready = 1'b0;
   logic [7:0]  job_kernel;
   logic [9:0]  job_row_base;
   logic [9:0]  job_out_row;
   logic        job_last;
   logic        row_done = 1'b0;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;
   int dv_cnt  = 0;   // cycles with CMD_DONE_VALID high
   int jv_cnt  = 0;   // cycles with job_valid high

   always #5 clk_a = ~clk_a;

   conv_sequencer #(.IFMAP_SIZE(32)) dut (
      .clk_a            (clk_a),
      .arstz_aq         (arstz_aq),
      .CMD_START        (CMD_START),
      .MODE_KERNEL_SIZE (MODE_KERNEL_SIZE),
      .MODE_KERNEL_NUMS (MODE_KERNEL_NUMS),
      .MODE_STRIDE      (MODE_STRIDE),
      .MODE_PADDING     (MODE_PADDING),
      .CMD_DONE         (CMD_DONE),
      .CMD_DONE_VALID   (CMD_DONE_VALID),
      .job_valid        (job_valid),
      .job_ready        (job_ready),
      .job_kernel       (job_kernel),
      .job_row_base     (job_row_base),
      .job_out_row      (job_out_row),
      .job_last         (job_last),
      .row_done         (row_done),
      .busy             (busy)
   );

   always @(negedge clk_a) begin
      if (CMD_DONE_VALID === 1'b1) dv_cnt++;
      if (job_valid === 1'b1) jv_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_a);
      #1;
   endtask

   // Runs one legal command with the PE side answering every job; expected
   // job coordinates come from hand-computed per-kernel / total counts.
   task automatic run_cmd(input string name, input logic [7:0] k, input logic [7:0] n,
                          input logic [1:0] s, input logic pad, input int per_kernel,
                          input int total, input int last_rb, input bit stall);
      int dv0;
      int t;
      int rb_seen;
      dv0 = dv_cnt;
      rb_seen = -1;
      MODE_KERNEL_SIZE = k;
      MODE_KERNEL_NUMS = n;
      MODE_STRIDE      = s;
      MODE_PADDING     = pad;
      CMD_START        = 1'b1;
      tick;
      chk({name, "_check_busy"}, 32'(busy), 32'd1);
      chk({name, "_check_novalid"}, 32'(job_valid), 32'd0);
      tick;
      chk({name, "_first_valid"}, 32'(job_valid), 32'd1);
      // Mode changes mid-command must not matter.
      MODE_KERNEL_SIZE = 8'd0;
      MODE_KERNEL_NUMS = 8'd0;
      MODE_STRIDE      = 2'd0;
      MODE_PADDING     = ~pad;
      for (int idx = 0; idx < total; idx++) begin
         t = 0;
         while (job_valid !== 1'b1 && t < 20) begin
            tick;
            t++;
         end
         chk({name, "_valid"}, 32'(job_valid), 32'd1);
         chk({name, "_kernel"}, 32'(job_kernel), 32'(idx / per_kernel));
         chk({name, "_row_base"}, 32'(job_row_base), 32'((idx % per_kernel) * int'(s)));
         chk({name, "_out_row"}, 32'(job_out_row), 32'(idx % per_kernel));
         chk({name, "_last"}, 32'(job_last), 32'(idx == total - 1));
         rb_seen = int'(job_row_base);
         if (stall && idx == 0) begin
            for (int c = 0; c < 5; c++) begin
               row_done = (c == 2);
               tick;
               row_done = 1'b0;
               chk({name, "_stall_valid"}, 32'(job_valid), 32'd1);
               chk({name, "_stall_fields"},
                   {job_kernel, 2'b00, job_row_base, 2'b00, job_out_row},
                   32'd0);
            end
         end
         job_ready = 1'b1;
         tick;
         job_ready = 1'b0;
         chk({name, "_wait_novalid"}, 32'(job_valid), 32'd0);
         tick;
         row_done = 1'b1;
         tick;
         row_done = 1'b0;
      end
      chk({name, "_last_row_base"}, 32'(rb_seen), 32'(last_rb));
      chk({name, "_done_valid"}, 32'(CMD_DONE_VALID), 32'd1);
      chk({name, "_done_ok"}, 32'(CMD_DONE), 32'd1);
      chk({name, "_busy_in_done"}, 32'(busy), 32'd1);
      tick;
      chk({name, "_strobe_end"}, 32'(CMD_DONE_VALID), 32'd0);
      chk({name, "_idle_busy"}, 32'(busy), 32'd0);
      chk({name, "_done_hold"}, 32'(CMD_DONE), 32'd1);
      // CMD_START is still high: no restart allowed.
      tick;
      tick;
      chk({name, "_no_restart"}, 32'(busy), 32'd0);
      chk({name, "_strobe_once"}, 32'(dv_cnt - dv0), 32'd1);
      CMD_START = 1'b0;
      tick;
   endtask

   initial begin
      int dv0;
      int jv0;

      // Reset state
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(job_valid), 32'd0);
      chk("rst_done", 32'(CMD_DONE), 32'd0);
      chk("rst_done_valid", 32'(CMD_DONE_VALID), 32'd0);
      chk("rst_fields", {job_kernel, 2'b00, job_row_base, 2'b00, job_out_row}, 32'd0);
      chk("rst_last", 32'(job_last), 32'd0);
      repeat (3) @(posedge clk_a);
      #2;
      arstz_aq = 1'b1;
      tick;

      // K=3 N=2 S=1 no pad: P=32, 30 rows per kernel, last row_base 29
      run_cmd("a", 8'd3, 8'd2, 2'd1, 1'b0, 30, 60, 29, 1'b1);
      // K=3 N=1 S=2 pad: P=34, 16 jobs, row_base 0..30
      run_cmd("b", 8'd3, 8'd1, 2'd2, 1'b1, 16, 16, 30, 1'b0);
      // K=5 N=1 S=3 pad: P=36, 11 jobs, final row_base 30
      run_cmd("c", 8'd5, 8'd1, 2'd3, 1'b1, 11, 11, 30, 1'b0);
      // K==P boundary: a single job that is also the last
      run_cmd("kp", 8'd32, 8'd1, 2'd1, 1'b0, 1, 1, 0, 1'b0);

      // S=0 config error
      dv0 = dv_cnt;
      jv0 = jv_cnt;
      MODE_KERNEL_SIZE = 8'd3;
      MODE_KERNEL_NUMS = 8'd1;
      MODE_STRIDE      = 2'd0;
      MODE_PADDING     = 1'b0;
      CMD_START        = 1'b1;
      tick;
      chk("err_s_check_nodv", 32'(CMD_DONE_VALID), 32'd0);
      tick;
      chk("err_s_dv", 32'(CMD_DONE_VALID), 32'd1);
      chk("err_s_status", 32'(CMD_DONE), 32'd0);
      chk("err_s_novalid", 32'(job_valid), 32'd0);
      tick;
      chk("err_s_strobe_end", 32'(CMD_DONE_VALID), 32'd0);
      chk("err_s_idle", 32'(busy), 32'd0);
      CMD_START = 1'b0;
      tick;
      chk("err_s_no_jobs", 32'(jv_cnt - jv0), 32'd0);
      chk("err_s_strobe_once", 32'(dv_cnt - dv0), 32'd1);

      // K > P config error (K=40, P=32)
      jv0 = jv_cnt;
      MODE_KERNEL_SIZE = 8'd40;
      MODE_STRIDE      = 2'd1;
      CMD_START        = 1'b1;
      tick;
      tick;
      chk("err_kp_dv", 32'(CMD_DONE_VALID), 32'd1);
      chk("err_kp_status", 32'(CMD_DONE), 32'd0);
      CMD_START = 1'b0;
      tick;
      chk("err_kp_no_jobs", 32'(jv_cnt - jv0), 32'd0);

      // Reset while waiting for row_done
      MODE_KERNEL_SIZE = 8'd3;
      MODE_KERNEL_NUMS = 8'd1;
      MODE_STRIDE      = 2'd1;
      MODE_PADDING     = 1'b0;
      CMD_START        = 1'b1;
      tick;
      tick;
      job_ready = 1'b1;
      tick;
      job_ready = 1'b0;
      row_done  = 1'b1;   // moves to out_row 1, so fields are non-zero
      tick;
      row_done  = 1'b0;
      job_ready = 1'b1;
      tick;
      job_ready = 1'b0;
      chk("rstw_in_wait", {30'd0, busy, job_valid}, 32'd2);
      chk("rstw_nonzero_row", 32'(job_out_row), 32'd1);
      dv0 = dv_cnt;
      #2;
      arstz_aq = 1'b0;
      #1;
      chk("rstw_busy", 32'(busy), 32'd0);
      chk("rstw_valid", 32'(job_valid), 32'd0);
      chk("rstw_fields", {job_kernel, 2'b00, job_row_base, 2'b00, job_out_row}, 32'd0);
      chk("rstw_last_done", {30'd0, job_last, CMD_DONE_VALID}, 32'd0);
      chk("rstw_done", 32'(CMD_DONE), 32'd0);
      CMD_START = 1'b0;
      tick;
      tick;
      arstz_aq = 1'b1;
      row_done = 1'b1;
      tick;
      row_done = 1'b0;
      repeat (3) tick;
      chk("rstw_after_busy", 32'(busy), 32'd0);
      chk("rstw_no_strobe", 32'(dv_cnt - dv0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
